// File: rtl/xgxs_lane_sync.sv
// XGXS lane code-group alignment and synchronisation.
// Searches all ten bit offsets for a comma, locks onto one, and tracks lane sync.
module xgxs_lane_sync #(
    parameter int unsigned GOOD_CGS_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] code_in,
    output logic [9:0] code_out,
    output logic       comma_out,
    output logic       sync_status,
    output logic [3:0] align_offset
);

    localparam logic [2:0] LOSS_OF_SYNC = 3'd0;
    localparam logic [2:0] COMMA_DET_1  = 3'd1;
    localparam logic [2:0] COMMA_DET_2  = 3'd2;
    localparam logic [2:0] COMMA_DET_3  = 3'd3;
    localparam logic [2:0] SYNC_ACQ_1   = 3'd4;
    localparam logic [2:0] SYNC_ACQ_2   = 3'd5;
    localparam logic [2:0] SYNC_ACQ_3   = 3'd6;
    localparam logic [2:0] SYNC_ACQ_4   = 3'd7;

    logic [9:0]  prev_in;
    logic [19:0] window;
    logic [9:0]  cand [10];
    logic [9:0]  comma_hit;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [1:0]  good_cgs;
    logic [1:0]  good_nxt;
    logic [1:0]  good_inc;
    logic        good_hit;
    logic [3:0]  align_nxt;
    logic [3:0]  first_k;
    logic [9:0]  cur_word;
    logic        cur_comma;
    logic        other_comma;
    logic        pop_ok;
    logic        invalid;

    always_comb begin
        window = {prev_in, code_in};
        for (int unsigned k = 0; k < 10; k++) begin
            cand[k]      = 10'(window >> (10 - k));
            comma_hit[k] = (cand[k][9:3] == 7'b0011111) || (cand[k][9:3] == 7'b1100000);
        end
    end

    // A comma outside the locked offset disqualifies the locked word.
    always_comb begin
        first_k     = '0;
        cur_word    = '0;
        cur_comma   = 1'b0;
        other_comma = 1'b0;
        for (int unsigned k = 10; k > 0; k--) begin
            if (comma_hit[k-1]) first_k = 4'(k - 1);
        end
        for (int unsigned k = 0; k < 10; k++) begin
            if (align_offset == 4'(k)) begin
                cur_word  = cand[k];
                cur_comma = comma_hit[k];
            end else if (comma_hit[k]) begin
                other_comma = 1'b1;
            end
        end
        pop_ok  = ($countones(cur_word) >= 4) && ($countones(cur_word) <= 6);
        invalid = !pop_ok || other_comma;
    end

    always_comb begin
        good_inc  = (good_cgs == 2'b11) ? 2'b11 : good_cgs + 2'd1;
        good_hit  = (32'(good_inc) == GOOD_CGS_MAX);
        state_nxt = state;
        good_nxt  = '0;
        align_nxt = align_offset;
        case (state)
            LOSS_OF_SYNC: begin
                if (|comma_hit) begin
                    state_nxt = COMMA_DET_1;
                    align_nxt = first_k;
                end
            end
            COMMA_DET_1, COMMA_DET_2, COMMA_DET_3: begin
                if (invalid)        state_nxt = LOSS_OF_SYNC;
                else if (cur_comma) state_nxt = state + 3'd1;
            end
            SYNC_ACQ_1: begin
                if (invalid) state_nxt = SYNC_ACQ_2;
            end
            SYNC_ACQ_2, SYNC_ACQ_3, SYNC_ACQ_4: begin
                if (invalid) begin
                    state_nxt = (state == SYNC_ACQ_4) ? LOSS_OF_SYNC : state + 3'd1;
                end else if (good_hit) begin
                    state_nxt = state - 3'd1;
                end else begin
                    good_nxt = good_inc;
                end
            end
            default: state_nxt = LOSS_OF_SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_in      <= '0;
            state        <= LOSS_OF_SYNC;
            good_cgs     <= '0;
            align_offset <= '0;
            code_out     <= '0;
            comma_out    <= 1'b0;
            sync_status  <= 1'b0;
        end else begin
            prev_in      <= code_in;
            state        <= state_nxt;
            good_cgs     <= good_nxt;
            align_offset <= align_nxt;
            code_out     <= cur_word;
            comma_out    <= cur_comma;
            sync_status  <= state[2];
        end
    end

endmodule

// File: tb/tb_xgxs_lane_sync.sv
// Bench for xgxs_lane_sync: scenario tasks plus randomized stream checked
// against a bit-stream reference model.
module tb_xgxs_lane_sync;

    localparam int GOOD_MAX = 3;
    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D000 = 10'b1001110100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] code_in = '0;
    logic [9:0] code_out;
    logic       comma_out;
    logic       sync_status;
    logic [3:0] align_offset;

    int checks = 0;
    int passed = 0;

    // model: phase 0 = hunting, 1 = comma detect, 2 = in sync; level = n of the state
    logic [9:0] m_prev, m_code;
    bit         m_comma, m_sync;
    int         m_align, m_phase, m_level, m_good;
    bit         bitq[$];

    always #5 clk = ~clk;

    xgxs_lane_sync #(.GOOD_CGS_MAX(GOOD_MAX)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .code_out(code_out),
        .comma_out(comma_out), .sync_status(sync_status), .align_offset(align_offset)
    );

    function automatic bit is_comma(input logic [9:0] w);
        return (w[9:3] == 7'b0011111) || (w[9:3] == 7'b1100000);
    endfunction

    function automatic void model_clk(input logic [9:0] din, input logic r);
        logic [19:0] win;
        logic [9:0]  wd, cur;
        int          first, pc;
        bit          others, bad, ccur;
        if (r) begin
            m_prev = '0; m_code = '0; m_comma = 0; m_sync = 0;
            m_align = 0; m_phase = 0; m_level = 1; m_good = 0;
            return;
        end
        win = {m_prev, din};
        first = -1; others = 0; cur = '0; ccur = 0;
        for (int k = 0; k < 10; k++) begin
            wd = 10'(win >> (10 - k));
            if (is_comma(wd) && first < 0) first = k;
            if (is_comma(wd) && k != m_align) others = 1;
            if (k == m_align) begin cur = wd; ccur = is_comma(wd); end
        end
        pc = $countones(cur);
        bad = (pc < 4) || (pc > 6) || others;
        m_code = cur; m_comma = ccur; m_sync = (m_phase == 2);
        case (m_phase)
            0: if (first >= 0) begin m_phase = 1; m_level = 1; m_align = first; end
            1: begin
                if (bad) m_phase = 0;
                else if (ccur) begin
                    if (m_level == 3) begin m_phase = 2; m_level = 1; end
                    else m_level++;
                end
            end
            default: begin
                if (m_level == 1) begin
                    if (bad) begin m_level = 2; m_good = 0; end
                end else if (bad) begin
                    m_good = 0;
                    if (m_level == 4) m_phase = 0; else m_level++;
                end else if (m_good + 1 == GOOD_MAX) begin
                    m_level--; m_good = 0;
                end else if (m_good < 3) m_good++;
            end
        endcase
        m_prev = din;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {code_out, comma_out, sync_status, align_offset};
    endfunction

    function automatic logic [15:0] model_vec();
        return {m_code, m_comma, m_sync, 4'(m_align)};
    endfunction

    task automatic push_sym(input logic [9:0] s);
        for (int i = 9; i >= 0; i--) bitq.push_back(s[i]);
    endtask

    task automatic next_word(output logic [9:0] w);
        while (bitq.size() < 10) begin push_sym(K285); push_sym(D000); end
        for (int i = 9; i >= 0; i--) w[i] = bitq.pop_front();
    endtask

    task automatic step(input logic [9:0] din);
        code_in = din;
        @(posedge clk);
        model_clk(din, rst);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0);
        step('0);
        rst = 1'b0;
        bitq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(10'($urandom));
            checks++;
            if (dut_vec() !== 16'h0) $display("FAIL reset_outputs: got %h expected 0000", dut_vec());
            else passed++;
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL reset_model: got %h expected %h", dut_vec(), model_vec());
            else passed++;
        end
        rst = 1'b0;
        bitq.delete();
    endtask

    task automatic test_acquire();
        logic [9:0] w;
        int first_sync = -1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            next_word(w);
            step(w);
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL acquire cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
            if (sync_status === 1'b1 && first_sync < 0) first_sync = i;
        end
        checks++;
        if (first_sync != 8) $display("FAIL acquire_latency: got %0d expected 8", first_sync);
        else passed++;
        checks++;
        if (align_offset !== 4'd0) $display("FAIL acquire_offset: got %0d expected 0", align_offset);
        else passed++;
    endtask

    task automatic test_misaligned();
        logic [9:0] w;
        bit expect_d = 0;
        int pairs = 0;
        do_reset();
        for (int i = 0; i < 3; i++) bitq.push_back(1'b0);
        for (int i = 0; i < 40; i++) begin
            next_word(w);
            step(w);
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL misaligned cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
            if (expect_d) begin
                checks++;
                if (code_out !== D000) $display("FAIL misaligned_d00: got %b expected %b", code_out, D000);
                else begin passed++; pairs++; end
                expect_d = 0;
            end else if (sync_status === 1'b1 && comma_out === 1'b1) begin
                checks++;
                if (code_out !== K285) $display("FAIL misaligned_k285: got %b expected %b", code_out, K285);
                else passed++;
                expect_d = 1;
            end
        end
        checks++;
        if (align_offset !== 4'd3) $display("FAIL misaligned_offset: got %0d expected 3", align_offset);
        else passed++;
        checks++;
        if (sync_status !== 1'b1 || pairs < 3) $display("FAIL misaligned_sync: got sync %b pairs %0d expected 1 and >=3", sync_status, pairs);
        else passed++;
    endtask

    task automatic test_loss();
        logic [9:0] w;
        do_reset();
        for (int i = 0; i < 12; i++) begin next_word(w); step(w); end
        for (int i = 0; i < 4; i++) begin
            step(10'h000);
            checks++;
            if (dut_vec() !== model_vec() || sync_status !== 1'b1)
                $display("FAIL loss_bad %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
        end
        next_word(w); step(w);
        checks++;
        if (sync_status !== 1'b1) $display("FAIL loss_lag: got sync %b expected 1", sync_status);
        else passed++;
        next_word(w); step(w);
        checks++;
        if (sync_status !== 1'b0) $display("FAIL loss_drop: got sync %b expected 0", sync_status);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            next_word(w); step(w);
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL loss_after %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
        end
    endtask

    task automatic test_recovery();
        logic [9:0] w;
        do_reset();
        for (int i = 0; i < 12; i++) begin next_word(w); step(w); end
        for (int i = 0; i < 20; i++) begin
            // one bad word, three good ones, then three bad: only a recovered lane survives
            if (i == 0 || (i >= 4 && i <= 6)) w = 10'h000;
            else next_word(w);
            step(w);
            checks++;
            if (dut_vec() !== model_vec() || sync_status !== 1'b1)
                $display("FAIL recovery cyc %0d: got %h expected %h with sync 1", i, dut_vec(), model_vec());
            else passed++;
        end
    endtask

    task automatic test_offset_hop();
        logic [9:0] w;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if (i == 4) bitq.push_back(1'b0);
            next_word(w);
            step(w);
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL hop cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
            if (i == 6) begin
                checks++;
                if (align_offset !== 4'd0) $display("FAIL hop_before: got %0d expected 0", align_offset);
                else passed++;
            end
            if (i == 7) begin
                checks++;
                if (align_offset !== 4'd1) $display("FAIL hop_relock: got %0d expected 1", align_offset);
                else passed++;
            end
        end
        checks++;
        if (sync_status !== 1'b1 || align_offset !== 4'd1) $display("FAIL hop_final: got sync %b off %0d expected 1 and 1", sync_status, align_offset);
        else passed++;
    endtask

    task automatic test_reset_mid_lock();
        logic [9:0] w;
        int first_sync = -1;
        do_reset();
        for (int i = 0; i < 10; i++) begin next_word(w); step(w); end
        rst = 1'b1;
        next_word(w);
        step(w);
        checks++;
        if (dut_vec() !== 16'h0) $display("FAIL midreset_outputs: got %h expected 0000", dut_vec());
        else passed++;
        rst = 1'b0;
        bitq.delete();
        for (int i = 0; i < 12; i++) begin
            next_word(w); step(w);
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL midreset cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
            if (sync_status === 1'b1 && first_sync < 0) first_sync = i;
        end
        checks++;
        if (first_sync != 8) $display("FAIL midreset_latency: got %0d expected 8", first_sync);
        else passed++;
    endtask

    task automatic test_random();
        logic [9:0] w;
        int r;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 199);
            if (r < 4) begin
                for (int b = 0; b < $urandom_range(1, 9); b++) bitq.push_back(1'($urandom));
            end
            if (r >= 4 && r < 14) w = 10'($urandom);
            else next_word(w);
            rst = (r == 199);
            step(w);
            rst = 1'b0;
            checks++;
            if (dut_vec() !== model_vec()) $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec(), model_vec());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_misaligned();
        test_loss();
        test_recovery();
        test_offset_hop();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/xgxs_lane_sync.md
XGXS_LANE_SYNC -- requirements
Module: xgxs_lane_sync

Interface
REQ-001 SHALL have parameter GOOD_CGS_MAX, default 3, the number of consecutive valid code groups that steps a SYNC_ACQ_n state back by one.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high (rst, clk).
REQ-004 SHALL have port code_in, input, 10, raw 8b10b bits, not yet aligned; bit 9 = 'a' (first on line), bit 0 = 'j'.
REQ-005 SHALL have port code_out, output, 10, aligned code group, registered.
REQ-006 SHALL have port comma_out, output, 1, code_out carries a comma.
REQ-007 SHALL have port sync_status, output, 1, lane is in a SYNC_ACQ state.
REQ-008 SHALL have port align_offset, output, 4, locked bit offset 0..9.

Function
REQ-009 SHALL keep prev_in, a 10-bit register holding code_in from the previous cycle; window W = {prev_in, code_in} (20 bits).
REQ-010 SHALL form candidate word_k = W[19-k : 10-k] for k = 0..9.
REQ-011 SHALL treat word_k as a comma when word_k[9:3] is 7'b0011111 or 7'b1100000.
REQ-012 SHALL treat a word as valid when its popcount is 4, 5 or 6 and it is not a comma at an offset other than the locked one.
REQ-013 SHALL have states LOSS_OF_SYNC, COMMA_DET_1, COMMA_DET_2, COMMA_DET_3, SYNC_ACQ_1, SYNC_ACQ_2, SYNC_ACQ_3 and SYNC_ACQ_4, encoded in 3 bits.
REQ-014 In LOSS_OF_SYNC, SHALL move to COMMA_DET_1 on any comma at any offset and lock align_offset to the lowest k that holds a comma; with no comma, SHALL stay and keep align_offset.
REQ-015 In COMMA_DET_n, judged on word_{align_offset}: comma -> next state (COMMA_DET_3 -> SYNC_ACQ_1); valid non-comma -> stay; invalid -> LOSS_OF_SYNC.
REQ-016 In SYNC_ACQ_1: valid -> stay; invalid -> SYNC_ACQ_2 with good_cgs cleared.
REQ-017 In SYNC_ACQ_n, n = 2..4: invalid -> SYNC_ACQ_(n+1), or LOSS_OF_SYNC from SYNC_ACQ_4, with good_cgs cleared.
REQ-018 In SYNC_ACQ_n, n = 2..4: valid -> good_cgs+1; when good_cgs reaches GOOD_CGS_MAX, SHALL go to SYNC_ACQ_(n-1) with good_cgs cleared.
REQ-019 good_cgs SHALL be a 2-bit saturating counter that is only active in SYNC_ACQ_2..4.
REQ-020 align_offset SHALL change only on the LOSS_OF_SYNC -> COMMA_DET_1 transition.
REQ-021 A comma at an offset other than align_offset SHALL count as invalid in all states except LOSS_OF_SYNC.
REQ-022 code_out and comma_out SHALL be registered from word_{align_offset} as it stands before any relock.
REQ-023 Latency at offset 0: code_in at cycle t appears on code_out at cycle t+2.
REQ-024 Latency at offset k > 0: code_out at cycle t+1 is built from prev_in and code_in as they are at cycle t.
REQ-025 sync_status SHALL be registered, equal 1 exactly when the state is SYNC_ACQ_1..4, and follow the state with one cycle of lag.
REQ-026 When the comma test and the invalid test both apply in the same cycle, the invalid test SHALL take priority.

Reset
REQ-027 While rst is high at a clock edge: state = LOSS_OF_SYNC, good_cgs = 0, prev_in = 0, code_out = 0, comma_out = 0, sync_status = 0, align_offset = 0.
REQ-028 rst asserted in the middle of operation SHALL override every transition on that edge.
REQ-029 The first window after reset SHALL use prev_in = 0.

Verification
REQ-030 Acquire: after reset, the aligned stream K28.5 (0011111010), D0.0, K28.5, D0.0, ... -> sync_status = 1 one cycle after the fourth comma is judged; align_offset = 0.
REQ-031 Misaligned: the same stream delayed by 3 bits -> align_offset = 3, sync_status = 1, and code_out reproduces 0011111010 and 1001110100 (D0.0 RD-) in that order.
REQ-032 Loss: in sync, inject 4 consecutive words of 10'h000 (popcount 0) -> states SYNC_ACQ_2, 3, 4, then LOSS_OF_SYNC; sync_status drops 1 cycle after the fourth bad word.
REQ-033 Recovery: in SYNC_ACQ_2, send 3 valid words -> SYNC_ACQ_1; sync_status stays 1 throughout.
REQ-034 Offset hop: in COMMA_DET_2, send a comma at offset+1 -> LOSS_OF_SYNC, then relock at the new offset on the next comma.
REQ-035 Reset mid-lock: pulse rst while in SYNC_ACQ_1 -> every output is 0 on the next cycle, then reacquisition follows the REQ-030 sequence.
